// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare/bimodal branch predictor with BTB.
package bp_pkg;

    typedef enum logic {BP_INIT, BP_RUN} bp_state_e;

    function automatic logic [31:0] ctr_weak_taken_f(input int unsigned ctr_bits);
        return 32'd1 << (ctr_bits - 1);
    endfunction

    function automatic logic [31:0] ctr_weak_not_taken_f(input int unsigned ctr_bits);
        return (32'd1 << (ctr_bits - 1)) - 32'd1;
    endfunction

    // Word-aligned PC bits folded with the global history, masked to the table size.
    function automatic logic [31:0] idx_f(input logic [31:0] pc, input logic [31:0] ghr,
                                          input int unsigned idx_bits);
        return ((pc >> 2) ^ ghr) & ((32'd1 << idx_bits) - 32'd1);
    endfunction

    function automatic logic [31:0] tag_f(input logic [31:0] pc, input int unsigned idx_bits,
                                          input int unsigned tag_bits);
        return (pc >> (idx_bits + 2)) & ((32'd1 << tag_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Saturating up/down direction counter, next-value logic only.
module bp_sat_ctr #(
    parameter int unsigned CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] cur,
    input  logic                taken,
    output logic [CTR_BITS-1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur != '1) nxt = cur + 1'b1;
        end else begin
            if (cur != '0) nxt = cur - 1'b1;
        end
    end

endmodule

// File: rtl/bp_gshare_btb.sv
// Tagged BTB plus saturating direction counters, indexed bimodally or by PC XOR history.
module bp_gshare_btb import bp_pkg::*; #(
    parameter int unsigned ENTRIES  = 64,
    parameter int unsigned CTR_BITS = 2,
    parameter int unsigned TAG_BITS = 8,
    parameter int unsigned GHR_BITS = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid_i,
    input  logic [31:0] pc_i,
    output logic        pre_taken_o,
    output logic [31:0] pre_addr_o,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_cond_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_target_i,
    input  logic        upd_mispred_i,
    output logic        busy_o,
    output logic [31:0] stat_upd_o,
    output logic [31:0] stat_mis_o
);

    localparam int unsigned IDX = $clog2(ENTRIES);
    localparam int unsigned GW  = (GHR_BITS == 0) ? 1 : GHR_BITS;
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(ctr_weak_taken_f(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'(ctr_weak_not_taken_f(CTR_BITS));

    bp_state_e           state_q, state_d;
    logic [IDX-1:0]      ptr_q, ptr_d;
    logic [GW-1:0]       ghr_q, ghr_d;
    logic [31:0]         stat_upd_q, stat_upd_d;
    logic [31:0]         stat_mis_q, stat_mis_d;

    logic                valid_q [ENTRIES];
    logic                jump_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q   [ENTRIES];
    logic [29:0]         tgt_q   [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q   [ENTRIES];

    logic                wr_en, wr_valid, wr_jump;
    logic [IDX-1:0]      wr_idx;
    logic [TAG_BITS-1:0] wr_tag;
    logic [29:0]         wr_tgt;
    logic [CTR_BITS-1:0] wr_ctr;

    logic [31:0]         ghr_ext;
    logic [IDX-1:0]      lk_idx, up_idx;
    logic [TAG_BITS-1:0] lk_tag, up_tag;
    logic [29:0]         up_tgt;
    logic                up_hit;
    logic [CTR_BITS-1:0] ctr_nxt;

    // With no history the index degenerates to plain bimodal.
    assign ghr_ext = (GHR_BITS == 0) ? 32'd0 : 32'(ghr_q);

    assign lk_idx = IDX'(idx_f(pc_i, ghr_ext, IDX));
    assign lk_tag = TAG_BITS'(tag_f(pc_i, IDX, TAG_BITS));
    assign up_idx = IDX'(idx_f(upd_pc_i, ghr_ext, IDX));
    assign up_tag = TAG_BITS'(tag_f(upd_pc_i, IDX, TAG_BITS));
    assign up_tgt = 30'(upd_target_i >> 2);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    bp_sat_ctr #(
        .CTR_BITS(CTR_BITS)
    ) u_sat_ctr (
        .cur  (ctr_q[up_idx]),
        .taken(upd_taken_i),
        .nxt  (ctr_nxt)
    );

    // Lookup reads the registered table, so a same-cycle update is seen one cycle later.
    assign pre_taken_o = (state_q == BP_RUN) && fetch_valid_i && valid_q[lk_idx] &&
                         (tag_q[lk_idx] == lk_tag) &&
                         (jump_q[lk_idx] || ctr_q[lk_idx][CTR_BITS-1]);
    assign pre_addr_o  = pre_taken_o ? {tgt_q[lk_idx], 2'b00} : 32'd0;
    assign busy_o      = (state_q == BP_INIT);
    assign stat_upd_o  = stat_upd_q;
    assign stat_mis_o  = stat_mis_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        ghr_d      = ghr_q;
        stat_upd_d = stat_upd_q;
        stat_mis_d = stat_mis_q;
        wr_en      = 1'b0;
        wr_idx     = up_idx;
        wr_valid   = 1'b1;
        wr_jump    = jump_q[up_idx];
        wr_tag     = up_tag;
        wr_tgt     = tgt_q[up_idx];
        wr_ctr     = ctr_q[up_idx];
        unique case (state_q)
            BP_INIT: begin
                wr_en    = 1'b1;
                wr_idx   = ptr_q;
                wr_valid = 1'b0;
                wr_jump  = 1'b0;
                wr_tag   = '0;
                wr_tgt   = '0;
                wr_ctr   = CTR_WNT;
                ptr_d    = ptr_q + 1'b1;
                if (ptr_q == IDX'(ENTRIES - 1)) state_d = BP_RUN;
            end
            BP_RUN: begin
                if (upd_valid_i) begin
                    if (up_hit) begin
                        wr_en = 1'b1;
                        if (upd_cond_i) wr_ctr = ctr_nxt;
                        if (upd_taken_i) wr_tgt = up_tgt;
                    end else if (upd_taken_i) begin
                        wr_en   = 1'b1;
                        wr_jump = ~upd_cond_i;
                        wr_tgt  = up_tgt;
                        wr_ctr  = CTR_WT;
                    end
                    if (upd_cond_i && (GHR_BITS != 0)) begin
                        ghr_d = (ghr_q << 1) | GW'(upd_taken_i);
                    end
                    if (stat_upd_q != '1) stat_upd_d = stat_upd_q + 32'd1;
                    if (upd_mispred_i && (stat_mis_q != '1)) stat_mis_d = stat_mis_q + 32'd1;
                end
            end
            default: state_d = BP_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= BP_INIT;
            ptr_q      <= '0;
            ghr_q      <= '0;
            stat_upd_q <= '0;
            stat_mis_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ghr_q      <= ghr_d;
            stat_upd_q <= stat_upd_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    // Table has no reset of its own; the INIT sweep clears it.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            valid_q[wr_idx] <= wr_valid;
            jump_q[wr_idx]  <= wr_jump;
            tag_q[wr_idx]   <= wr_tag;
            tgt_q[wr_idx]   <= wr_tgt;
            ctr_q[wr_idx]   <= wr_ctr;
        end
    end

endmodule

// File: tb/tb_bp_gshare_btb.sv
// Self-checking bench: a bimodal and a 4-bit-history predictor checked against a table model.
module tb_bp_gshare_btb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, fetch_valid, upd_valid, upd_cond, upd_taken, upd_mispred;
    logic [31:0] pc, upd_pc, upd_target;
    logic [1:0]       pt, busy;
    logic [1:0][31:0] pa, su, sm;

    bp_gshare_btb u_bim (
        .clk(clk), .rst(rst), .fetch_valid_i(fetch_valid), .pc_i(pc),
        .pre_taken_o(pt[0]), .pre_addr_o(pa[0]),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_cond_i(upd_cond),
        .upd_taken_i(upd_taken), .upd_target_i(upd_target), .upd_mispred_i(upd_mispred),
        .busy_o(busy[0]), .stat_upd_o(su[0]), .stat_mis_o(sm[0])
    );

    bp_gshare_btb #(.GHR_BITS(4)) u_gsh (
        .clk(clk), .rst(rst), .fetch_valid_i(fetch_valid), .pc_i(pc),
        .pre_taken_o(pt[1]), .pre_addr_o(pa[1]),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_cond_i(upd_cond),
        .upd_taken_i(upd_taken), .upd_target_i(upd_target), .upd_mispred_i(upd_mispred),
        .busy_o(busy[1]), .stat_upd_o(su[1]), .stat_mis_o(sm[1])
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: 64 entries, 2-bit counters, tag = PC[15:8]
    bit          m_valid [2][64];
    bit          m_jump  [2][64];
    int          m_tag   [2][64];
    int          m_ctr   [2][64];
    logic [31:0] m_tgt   [2][64];
    int          m_ghr   [2];
    int          m_gbits [2] = '{0, 4};
    bit          m_run   [2];
    int          m_ptr   [2];
    int          m_su    [2];
    int          m_sm    [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int midx(input int m, input logic [31:0] a);
        return int'(((a >> 2) ^ 32'(m_ghr[m])) & 32'h3F);
    endfunction

    function automatic int mtag(input logic [31:0] a);
        return int'((a >> 8) & 32'hFF);
    endfunction

    task automatic check_model();
        for (int m = 0; m < 2; m++) begin
            int i = midx(m, pc);
            bit t = m_run[m] && fetch_valid && m_valid[m][i] && (m_tag[m][i] == mtag(pc)) &&
                    (m_jump[m][i] || m_ctr[m][i] >= 2);
            chk($sformatf("busy[%0d]", m), {31'd0, busy[m]}, {31'd0, !m_run[m]});
            chk($sformatf("pre_taken[%0d]", m), {31'd0, pt[m]}, {31'd0, t});
            chk($sformatf("pre_addr[%0d]", m), pa[m], t ? m_tgt[m][i] : 32'd0);
            chk($sformatf("stat_upd[%0d]", m), su[m], 32'(m_su[m]));
            chk($sformatf("stat_mis[%0d]", m), sm[m], 32'(m_sm[m]));
        end
    endtask

    task automatic model_clock();
        for (int m = 0; m < 2; m++) begin
            if (!rst) begin
                m_run[m] = 0; m_ptr[m] = 0; m_ghr[m] = 0; m_su[m] = 0; m_sm[m] = 0;
            end else if (!m_run[m]) begin
                m_valid[m][m_ptr[m]] = 0;
                m_ctr[m][m_ptr[m]]   = 1;
                m_ptr[m]++;
                if (m_ptr[m] == 64) m_run[m] = 1;
            end else if (upd_valid) begin
                int i = midx(m, upd_pc);
                int tg = mtag(upd_pc);
                if (m_valid[m][i] && m_tag[m][i] == tg) begin
                    if (upd_cond) begin
                        if (upd_taken) m_ctr[m][i] = (m_ctr[m][i] == 3) ? 3 : m_ctr[m][i] + 1;
                        else           m_ctr[m][i] = (m_ctr[m][i] == 0) ? 0 : m_ctr[m][i] - 1;
                    end
                    if (upd_taken) m_tgt[m][i] = upd_target & 32'hFFFF_FFFC;
                end else if (upd_taken) begin
                    m_valid[m][i] = 1;
                    m_tag[m][i]   = tg;
                    m_tgt[m][i]   = upd_target & 32'hFFFF_FFFC;
                    m_jump[m][i]  = !upd_cond;
                    m_ctr[m][i]   = 2;
                end
                if (upd_cond && m_gbits[m] > 0) m_ghr[m] = ((m_ghr[m] << 1) | int'(upd_taken)) % 16;
                m_su[m]++;
                if (upd_mispred) m_sm[m]++;
            end
        end
    endtask

    task automatic tick();
        #1 check_model();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic upd(input logic [31:0] a, input bit c, input bit t, input logic [31:0] tg);
        upd_valid = 1; upd_pc = a; upd_cond = c; upd_taken = c ? t : 1'b1;
        upd_target = tg; upd_mispred = 0;
    endtask

    function automatic logic [31:0] pool_pc();
        return (($urandom % 4) << 8) | (($urandom % 64) << 2);
    endfunction

    task automatic rand_inputs();
        fetch_valid = ($urandom % 8) != 0;
        pc          = pool_pc();
        upd_valid   = ($urandom % 10) < 7;
        upd_pc      = pool_pc();
        upd_cond    = ($urandom % 2) == 1;
        upd_taken   = upd_cond ? (($urandom % 2) == 1) : 1'b1;
        upd_target  = $urandom;
        upd_mispred = ($urandom % 2) == 1;
    endtask

    initial begin
        int busy_cnt;
        rst = 0; fetch_valid = 1; pc = 32'h100; upd_valid = 0; upd_pc = 0;
        upd_cond = 0; upd_taken = 0; upd_target = 0; upd_mispred = 0;
        @(posedge clk);
        model_clock();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            rand_inputs();
            tick();
        end
        #1 chk("reset_busy", {31'd0, busy[0]}, 32'd1);
        chk("reset_taken", {31'd0, pt[0]}, 32'd0);

        // Sweep: busy for exactly 64 cycles, updates ignored
        rst = 1;
        busy_cnt = 0;
        while (busy[0] && busy_cnt < 200) begin
            rand_inputs();
            tick();
            busy_cnt++;
        end
        chk("init_cycles", 32'(busy_cnt), 32'd64);
        chk("init_no_count", su[0], 32'd0);
        upd_valid = 0;

        // History sensitivity: train 0x40 with ghr=0000, then drive ghr to 1010
        upd(32'h40, 1, 1, 32'h444); tick();
        upd(32'h800, 1, 0, 32'h0); tick();
        upd(32'h880, 1, 1, 32'h888); tick();
        upd(32'h800, 1, 0, 32'h0); tick();
        upd_valid = 0; pc = 32'h40; fetch_valid = 1;
        #1 chk("bim_0x40_taken", {31'd0, pt[0]}, 32'd1);
        chk("bim_0x40_addr", pa[0], 32'h444);
        chk("gsh_hist_1010_not_taken", {31'd0, pt[1]}, 32'd0);
        tick();

        // Basic allocate and one not-taken step
        upd(32'h100, 1, 1, 32'h200); tick();
        upd_valid = 0; pc = 32'h100;
        #1 chk("alloc_taken", {31'd0, pt[0]}, 32'd1);
        chk("alloc_addr", pa[0], 32'h200);
        tick();
        upd(32'h100, 1, 0, 32'h0); tick();
        upd_valid = 0;
        #1 chk("ctr1_not_taken", {31'd0, pt[0]}, 32'd0);
        tick();

        // Saturation at both ends
        for (int k = 0; k < 5; k++) begin upd(32'h100, 1, 1, 32'h200); tick(); end
        upd(32'h100, 1, 0, 32'h0); tick();
        upd_valid = 0;
        #1 chk("sat_hi_after_1nt", {31'd0, pt[0]}, 32'd1);
        upd(32'h100, 1, 0, 32'h0); tick();
        upd_valid = 0;
        #1 chk("sat_hi_after_2nt", {31'd0, pt[0]}, 32'd0);
        for (int k = 0; k < 3; k++) begin upd(32'h100, 1, 0, 32'h0); tick(); end
        upd(32'h100, 1, 1, 32'h200); tick();
        upd_valid = 0;
        #1 chk("sat_lo_plus1", {31'd0, pt[0]}, 32'd0);
        upd(32'h100, 1, 1, 32'h200); tick();
        upd_valid = 0;
        #1 chk("sat_lo_plus2", {31'd0, pt[0]}, 32'd1);

        // Same-cycle lookup and update to index 5
        pc = 32'h14; fetch_valid = 1;
        upd(32'h14, 1, 1, 32'h500);
        #1 chk("same_cycle_old", {31'd0, pt[0]}, 32'd0);
        tick();
        upd_valid = 0;
        #1 chk("same_cycle_new_taken", {31'd0, pt[0]}, 32'd1);
        chk("same_cycle_new_addr", pa[0], 32'h500);
        tick();

        // Jump allocation predicts taken regardless of counter
        upd(32'h3F0, 0, 1, 32'h1234); tick();
        upd_valid = 0; pc = 32'h3F0;
        #1 chk("jump_taken", {31'd0, pt[0]}, 32'd1);
        chk("jump_addr", pa[0], 32'h1234);
        tick();

        for (int k = 0; k < 400; k++) begin
            rand_inputs();
            tick();
        end

        // Reset mid-run, updates during sweep not counted, then 10 updates with 3 mispredicts
        rst = 0; upd_valid = 0;
        tick();
        #1 chk("midrst_upd_zero", su[0], 32'd0);
        chk("midrst_mis_zero", sm[0], 32'd0);
        chk("midrst_busy", {31'd0, busy[0]}, 32'd1);
        rst = 1;
        busy_cnt = 0;
        while (busy[0] && busy_cnt < 200) begin
            rand_inputs();
            upd_valid = 1;
            tick();
            busy_cnt++;
        end
        chk("reinit_cycles", 32'(busy_cnt), 32'd64);
        for (int k = 0; k < 10; k++) begin
            rand_inputs();
            upd_valid   = 1;
            upd_mispred = (k == 1 || k == 4 || k == 8);
            tick();
        end
        upd_valid = 0;
        #1 chk("stat_upd_10", su[0], 32'd10);
        chk("stat_mis_3", sm[0], 32'd3);
        chk("gsh_stat_upd_10", su[1], 32'd10);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
